if_pc_fetch: RTL and testbench

- PC register and instruction-fetch front end of the 32-bit LoongArch core.
- Drives the sequential PC (pc_seq) into in0 of the next-PC 2:1 select. The branch target enters in1; the select is the EX branch-taken signal.
- Consumes the select's output as nxt_pc.
- Issues one-outstanding requests on the instruction SRAM-like bus and hands {pc, inst} to ID with a valid/ready handshake, squashing stale fetches on redirect.

---
 rtl/if_pc_fetch.sv | 122 ++++++++++++
 tb/tb_if_pc_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_fetch.sv
// PC register and instruction-fetch front end: single-outstanding SRAM-like fetch with
// a valid/ready hand-off of {pc, inst} to ID and squashing of stale fetches on redirect.
module if_pc_fetch #(
  parameter int unsigned     WORD     = 32,
  parameter logic [WORD-1:0] RESET_PC = 32'h1C000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] nxt_pc,
  input  logic            redirect,
  output logic [WORD-1:0] pc_seq,
  output logic            inst_req,
  output logic [WORD-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [WORD-1:0] inst_rdata,
  output logic            id_valid,
  output logic [WORD-1:0] id_pc,
  output logic [WORD-1:0] id_inst,
  input  logic            id_ready
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StReq  = 3'd1,
    StWait = 3'd2,
    StHold = 3'd3,
    StDrop = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic            id_valid_q, id_valid_d;
  logic [WORD-1:0] id_pc_q, id_pc_d;
  logic [WORD-1:0] id_inst_q, id_inst_d;
  logic [WORD-1:0] nxt_pc_aligned;

  // Instruction addresses are word aligned; the low bits of the select output are dropped.
  assign nxt_pc_aligned = {nxt_pc[WORD-1:2], 2'b00};
  assign pc_seq         = pc_q + WORD'(4);

  assign inst_req  = (state_q == StReq);
  assign inst_addr = pc_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect) begin
          pc_d = nxt_pc_aligned;
        end
      end
      StReq: begin
        if (redirect) begin
          // A request accepted alongside a redirect still owes one response.
          state_d = inst_addr_ok ? StDrop : StReq;
        end else if (inst_addr_ok) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect) begin
          state_d = inst_data_ok ? StReq : StDrop;
        end else if (inst_data_ok) begin
          id_inst_d  = inst_rdata;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StReq;
        end else if (id_ready) begin
          id_valid_d = 1'b0;
          pc_d       = nxt_pc_aligned;
          state_d    = StReq;
        end
      end
      StDrop: begin
        if (inst_data_ok) begin
          state_d = StReq;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Redirect overrides every local decision once fetching has started.
    if (redirect && (state_q != StIdle)) begin
      pc_d       = nxt_pc_aligned;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// Bench for if_pc_fetch: directed scenarios, then randomized bus/ID/redirect traffic
// checked against a transaction-level scoreboard.
module tb_if_pc_fetch;

  localparam logic [31:0] RST_PC = 32'h1C000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] nxt_pc;
  logic        redirect;
  logic [31:0] pc_seq;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic [31:0] tgt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External next-PC select: sequential path unless the branch is taken.
  assign nxt_pc = redirect ? tgt : pc_seq;

  if_pc_fetch #(
    .WORD    (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .nxt_pc      (nxt_pc),
    .redirect    (redirect),
    .pc_seq      (pc_seq),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_ready    (id_ready)
  );

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } del_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (inst_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk1({tag, "_req"}, inst_req, 1'b1);
  endtask

  // Fetch one word at addr: addr_ok immediately, data_ok dlat cycles later; ends in HOLD.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] word,
                       input int dlat);
    wait_req(tag);
    chk({tag, "_addr"}, inst_addr, addr);
    chk({tag, "_seq"}, pc_seq, addr + 32'd4);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    for (int i = 1; i < dlat; i++) begin
      chk1({tag, "_noreq_wait"}, inst_req, 1'b0);
      tick();
    end
    chk1({tag, "_noreq"}, inst_req, 1'b0);
    inst_data_ok = 1'b1;
    inst_rdata   = word;
    tick();
    inst_data_ok = 1'b0;
    chk1({tag, "_valid"}, id_valid, 1'b1);
    chk({tag, "_idpc"}, id_pc, addr);
    chk({tag, "_idinst"}, id_inst, word);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_t        bq[$];
    del_t        dq[$];
    bus_t        e;
    logic [31:0] m_pc;
    int          dcnt;
    int          ndeliv;
    bit          hold;

    rst          = 1'b1;
    redirect     = 1'b0;
    tgt          = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    id_ready     = 1'b0;

    // Reset state.
    tick();
    tick();
    chk1("rst_req", inst_req, 1'b0);
    chk1("rst_valid", id_valid, 1'b0);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_idinst", id_inst, 32'h0);
    chk("rst_addr", inst_addr, RST_PC);
    chk("rst_seq", pc_seq, RST_PC + 32'd4);
    rst = 1'b0;
    chk1("idle_req", inst_req, 1'b0);
    tick();
    chk1("first_req", inst_req, 1'b1);

    // Back-to-back fetches, one instruction every three cycles.
    for (int i = 0; i < 3; i++) begin
      serve("seq", RST_PC + 32'(4 * i), 32'hA000_0000 + 32'(i), 1);
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      chk1("seq_drop_valid", id_valid, 1'b0);
      chk1("seq_next_req", inst_req, 1'b1);
    end

    // ID back-pressure for five cycles.
    serve("stall", 32'h1C00000C, 32'hB0B0_B0B0, 2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("stall_valid", id_valid, 1'b1);
      chk("stall_idpc", id_pc, 32'h1C00000C);
      chk("stall_idinst", id_inst, 32'hB0B0_B0B0);
      chk1("stall_noreq", inst_req, 1'b0);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk1("stall_req", inst_req, 1'b1);
    chk("stall_next_addr", inst_addr, 32'h1C000010);

    // Redirect coincident with address acceptance: one stale response owed.
    inst_addr_ok = 1'b1;
    redirect     = 1'b1;
    tgt          = 32'h1C000200;
    tick();
    inst_addr_ok = 1'b0;
    redirect     = 1'b0;
    chk1("drop_noreq", inst_req, 1'b0);
    tick();
    chk1("drop_noreq2", inst_req, 1'b0);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBADB_AD00;
    tick();
    inst_data_ok = 1'b0;
    chk1("drop_valid", id_valid, 1'b0);
    chk1("drop_req", inst_req, 1'b1);
    chk("drop_addr", inst_addr, 32'h1C000200);

    // Redirect while waiting for data; late 0xDEAD must never reach ID.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    redirect     = 1'b1;
    tgt          = 32'h1C000100;
    tick();
    redirect = 1'b0;
    chk1("wait_rd_noreq", inst_req, 1'b0);
    tick();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h0000_DEAD;
    tick();
    inst_data_ok = 1'b0;
    chk1("wait_rd_valid", id_valid, 1'b0);
    chk1("wait_rd_req", inst_req, 1'b1);
    chk("wait_rd_addr", inst_addr, 32'h1C000100);
    tick();
    chk1("wait_rd_valid2", id_valid, 1'b0);

    // PC wrap and alignment.
    redirect = 1'b1;
    tgt      = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    serve("wrap", 32'hFFFF_FFFC, 32'h1234_5678, 1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    chk1("wrap_req", inst_req, 1'b1);
    chk("wrap_addr", inst_addr, 32'h0000_0000);
    redirect = 1'b1;
    tgt      = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("align_addr", inst_addr, 32'h0000_0100);

    // Stray data_ok while requesting is ignored.
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h5555_5555;
    tick();
    inst_data_ok = 1'b0;
    chk1("stray_valid", id_valid, 1'b0);
    chk1("stray_req", inst_req, 1'b1);
    chk("stray_addr", inst_addr, 32'h0000_0100);

    // Redirect in HOLD wins over a simultaneous id_ready.
    serve("hold_rd", 32'h0000_0100, 32'hCAFE_F00D, 1);
    id_ready = 1'b1;
    redirect = 1'b1;
    tgt      = 32'h0000_0200;
    tick();
    id_ready = 1'b0;
    redirect = 1'b0;
    chk1("hold_rd_valid", id_valid, 1'b0);
    chk1("hold_rd_req", inst_req, 1'b1);
    chk("hold_rd_addr", inst_addr, 32'h0000_0200);

    // Asynchronous reset while in WAIT.
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk1("async_req", inst_req, 1'b0);
    chk1("async_valid", id_valid, 1'b0);
    chk("async_idpc", id_pc, 32'h0);
    chk("async_idinst", id_inst, 32'h0);
    chk("async_addr", inst_addr, RST_PC);
    tick();
    tick();
    rst = 1'b0;
    chk1("restart_idle", inst_req, 1'b0);
    tick();
    chk1("restart_req", inst_req, 1'b1);
    chk("restart_addr", inst_addr, RST_PC);

    // Randomized traffic against the scoreboard.
    m_pc   = RST_PC;
    dcnt   = 0;
    ndeliv = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      redirect     = ($urandom_range(0, 9) == 0);
      tgt          = $urandom();
      inst_addr_ok = inst_req && ($urandom_range(0, 1) == 1);
      inst_data_ok = 1'b0;
      if (bq.size() > 0) begin
        dcnt--;
        inst_data_ok = (dcnt <= 0);
      end
      inst_rdata = $urandom();
      id_ready   = ($urandom_range(0, 2) != 0);
      #1;

      chk1("r_valid", id_valid, dq.size() > 0);
      if (dq.size() > 0) begin
        chk("r_idpc", id_pc, dq[0].pc);
        chk("r_idinst", id_inst, dq[0].inst);
      end
      chk1("r_req", inst_req, (bq.size() == 0) && (dq.size() == 0));
      if (inst_req) begin
        chk("r_seq", pc_seq, m_pc + 32'd4);
      end
      if (inst_req && inst_addr_ok) begin
        chk("r_addr", inst_addr, m_pc);
      end

      hold = (dq.size() > 0);
      if (redirect) begin
        if (inst_data_ok) void'(bq.pop_front());
        foreach (bq[i]) bq[i].stale = 1'b1;
        if (inst_req && inst_addr_ok) begin
          bq.push_back('{pc: m_pc, stale: 1'b1});
          dcnt = $urandom_range(1, 3);
        end
        dq.delete();
        m_pc = {tgt[31:2], 2'b00};
      end else begin
        if (hold && id_ready) begin
          m_pc = dq[0].pc + 32'd4;
          void'(dq.pop_front());
          ndeliv++;
        end
        if (inst_req && inst_addr_ok) begin
          bq.push_back('{pc: m_pc, stale: 1'b0});
          dcnt = $urandom_range(1, 3);
        end
        if (inst_data_ok) begin
          e = bq.pop_front();
          if (!e.stale) dq.push_back('{pc: e.pc, inst: inst_rdata});
        end
      end
      tick();
    end
    chk1("r_progress", ndeliv >= 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
